rc4_engine: RTL and testbench

- Parametrised RC4 keystream engine that runs all three phases in sequence:
  - S-array init (S[i]=i)
  - key scheduling (KSA swap loop) with a KEY_BYTES-long secret key
  - PRGA keystream generation of OUT_LEN bytes
- Drives an external 256x8 single-port synchronous S memory (s_memory-style: registered address, q valid the cycle after the address is held).
- Streams keystream bytes out over a valid/ready handshake to the decrypt/compare stage.

---
 rtl/rc4_engine.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_rc4_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_engine.sv
// ---------------------------------------------------------------------------
// rc4_engine
//
// RC4 keystream generator. It runs three phases in sequence and uses an
// external 256x8 single-port synchronous S memory for all of them:
//   1. INIT : S[i] = i for i = 0..255, one write per cycle
//   2. KSA  : key scheduling swap loop using a KEY_BYTES-long key
//   3. PRGA : keystream generation of OUT_LEN bytes, sent over valid/ready
//
// The memory registers its address on the clock edge, and q becomes valid in
// the following cycle. Every read therefore uses two states: RD_x holds the
// address, and s_q is sampled at the end of WAIT_x.
//
// Parameters:
//   KEY_BYTES : secret key length in bytes (1..32)
//   OUT_LEN   : keystream bytes presented per start (1..65535)
//   DROP_N    : keystream bytes discarded before output (RC4_DROP_EN only)
//
// Optional feature macro: RC4_DROP_EN
//   When defined, the first DROP_N PRGA bytes are generated (the swaps are
//   performed) but are not presented. When undefined, DROP_N is ignored.
//
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   start      : one-cycle pulse; starts a full run from IDLE or DONE
//   secret_key : key; byte k = secret_key[(KEY_BYTES-1-k)*8 +: 8]
//   s_addr     : S memory address
//   s_wdata    : S memory write data
//   s_wren     : S memory write enable
//   s_q        : S memory read data
//   ks_data    : keystream byte
//   ks_valid   : ks_data valid
//   ks_ready   : consumer accepts ks_data
//   busy       : high from the cycle after start until DONE
//   done       : level; high in DONE, cleared by the next accepted start
// ---------------------------------------------------------------------------
module rc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int OUT_LEN   = 32,
  parameter int DROP_N    = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic [7:0]             ks_data,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic                   busy,
  output logic                   done
);

  // Elaboration-time parameter range checks
  if (KEY_BYTES < 1 || KEY_BYTES > 32) begin : g_bad_key_bytes
    $error("rc4_engine: KEY_BYTES must be in 1..32");
  end
  if (OUT_LEN < 1 || OUT_LEN > 65535) begin : g_bad_out_len
    $error("rc4_engine: OUT_LEN must be in 1..65535");
  end
  if (DROP_N < 0 || DROP_N > 65535) begin : g_bad_drop_n
    $error("rc4_engine: DROP_N must be in 0..65535");
  end

  localparam int              KW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]   K_LAST   = KW'(KEY_BYTES - 1);
  localparam logic [15:0]     OUT_LAST = 16'(OUT_LEN - 1);

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RD_I,
    ST_KSA_WAIT_I,
    ST_KSA_RD_J,
    ST_KSA_WAIT_J,
    ST_KSA_WR_I,
    ST_KSA_WR_J,
    ST_PRGA_RD_I,
    ST_PRGA_WAIT_I,
    ST_PRGA_RD_J,
    ST_PRGA_WAIT_J,
    ST_PRGA_WR_I,
    ST_PRGA_WR_J,
    ST_PRGA_RD_T,
    ST_PRGA_WAIT_T,
    ST_OUT,
    ST_DONE
  } state_t;

  state_t                 state_reg;
  logic [7:0]             i_reg;
  logic [7:0]             j_reg;
  logic [7:0]             si_reg;
  logic [7:0]             sj_reg;
  logic [KW-1:0]          k_reg;
  logic [15:0]            out_cnt_reg;
  logic [KEY_BYTES*8-1:0] key_reg;

  logic [7:0]             s_addr_reg;
  logic [7:0]             s_wdata_reg;
  logic                   s_wren_reg;
  logic [7:0]             ks_data_reg;
  logic                   ks_valid_reg;
  logic                   busy_reg;
  logic                   done_reg;

  // Split the latched key into bytes; byte 0 is the most significant byte.
  logic [7:0] key_bytes [KEY_BYTES];
  for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_bytes
    assign key_bytes[gi] = key_reg[(KEY_BYTES-1-gi)*8 +: 8];
  end

  // Key index wraps at KEY_BYTES rather than at a power of two.
  logic [KW-1:0] k_next;
  assign k_next = (k_reg == K_LAST) ? '0 : k_reg + 1'b1;

  // The new j is computed from s_q directly so that its read address can be
  // registered on the same edge that samples S[i].
  logic [7:0] j_ksa;
  logic [7:0] j_prga;
  logic [7:0] i_inc;
  assign j_ksa  = j_reg + s_q + key_bytes[k_reg];
  assign j_prga = j_reg + s_q;
  assign i_inc  = i_reg + 8'd1;

  // drop_byte: the byte just read from S[t] is discarded rather than presented
  logic drop_byte;
`ifdef RC4_DROP_EN
  localparam logic [15:0] DROP_LIMIT = 16'(DROP_N);
  logic [15:0] drop_cnt_reg;
  assign drop_byte = (drop_cnt_reg != DROP_LIMIT);
`else
  assign drop_byte = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      i_reg        <= '0;
      j_reg        <= '0;
      si_reg       <= '0;
      sj_reg       <= '0;
      k_reg        <= '0;
      out_cnt_reg  <= '0;
      key_reg      <= '0;
      s_addr_reg   <= '0;
      s_wdata_reg  <= '0;
      s_wren_reg   <= 1'b0;
      ks_data_reg  <= '0;
      ks_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef RC4_DROP_EN
      drop_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            key_reg     <= secret_key;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            i_reg       <= '0;
            j_reg       <= '0;
            out_cnt_reg <= '0;
`ifdef RC4_DROP_EN
            drop_cnt_reg <= '0;
`endif
            // First INIT write is already set up when INIT is entered
            s_addr_reg  <= 8'd0;
            s_wdata_reg <= 8'd0;
            s_wren_reg  <= 1'b1;
            state_reg   <= ST_INIT;
          end
        end

        ST_INIT: begin
          if (i_reg == 8'hFF) begin
            s_wren_reg <= 1'b0;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            s_addr_reg <= 8'd0;
            state_reg  <= ST_KSA_RD_I;
          end else begin
            i_reg       <= i_inc;
            s_addr_reg  <= i_inc;
            s_wdata_reg <= i_inc;
          end
        end

        // ---------------- KSA ----------------
        ST_KSA_RD_I: state_reg <= ST_KSA_WAIT_I;

        ST_KSA_WAIT_I: begin
          si_reg     <= s_q;
          j_reg      <= j_ksa;
          s_addr_reg <= j_ksa;
          k_reg      <= k_next;
          state_reg  <= ST_KSA_RD_J;
        end

        ST_KSA_RD_J: state_reg <= ST_KSA_WAIT_J;

        ST_KSA_WAIT_J: begin
          sj_reg      <= s_q;
          s_addr_reg  <= i_reg;
          s_wdata_reg <= s_q;
          s_wren_reg  <= 1'b1;
          state_reg   <= ST_KSA_WR_I;
        end

        ST_KSA_WR_I: begin
          s_addr_reg  <= j_reg;
          s_wdata_reg <= si_reg;
          state_reg   <= ST_KSA_WR_J;
        end

        // With i == j, the second write lands on the same address last,
        // leaving S[i] = si as required.
        ST_KSA_WR_J: begin
          s_wren_reg <= 1'b0;
          if (i_reg == 8'hFF) begin
            // PRGA starts from i = 0, j = 0. Its first step pre-increments i,
            // so i = 1 is loaded directly.
            i_reg      <= 8'd1;
            j_reg      <= '0;
            s_addr_reg <= 8'd1;
            state_reg  <= ST_PRGA_RD_I;
          end else begin
            i_reg      <= i_inc;
            s_addr_reg <= i_inc;
            state_reg  <= ST_KSA_RD_I;
          end
        end

        // ---------------- PRGA ----------------
        ST_PRGA_RD_I: state_reg <= ST_PRGA_WAIT_I;

        ST_PRGA_WAIT_I: begin
          si_reg     <= s_q;
          j_reg      <= j_prga;
          s_addr_reg <= j_prga;
          state_reg  <= ST_PRGA_RD_J;
        end

        ST_PRGA_RD_J: state_reg <= ST_PRGA_WAIT_J;

        ST_PRGA_WAIT_J: begin
          sj_reg      <= s_q;
          s_addr_reg  <= i_reg;
          s_wdata_reg <= s_q;
          s_wren_reg  <= 1'b1;
          state_reg   <= ST_PRGA_WR_I;
        end

        ST_PRGA_WR_I: begin
          s_addr_reg  <= j_reg;
          s_wdata_reg <= si_reg;
          state_reg   <= ST_PRGA_WR_J;
        end

        ST_PRGA_WR_J: begin
          s_wren_reg <= 1'b0;
          s_addr_reg <= si_reg + sj_reg;
          state_reg  <= ST_PRGA_RD_T;
        end

        ST_PRGA_RD_T: state_reg <= ST_PRGA_WAIT_T;

        ST_PRGA_WAIT_T: begin
          if (drop_byte) begin
`ifdef RC4_DROP_EN
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
`endif
            i_reg      <= i_inc;
            s_addr_reg <= i_inc;
            state_reg  <= ST_PRGA_RD_I;
          end else begin
            ks_data_reg  <= s_q;
            ks_valid_reg <= 1'b1;
            state_reg    <= ST_OUT;
          end
        end

        // Holds ks_data/ks_valid until the consumer takes the byte.
        ST_OUT: begin
          if (ks_ready) begin
            ks_valid_reg <= 1'b0;
            out_cnt_reg  <= out_cnt_reg + 16'd1;
            if (out_cnt_reg == OUT_LAST) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= ST_DONE;
            end else begin
              i_reg      <= i_inc;
              s_addr_reg <= i_inc;
              state_reg  <= ST_PRGA_RD_I;
            end
          end
        end

        default: begin
          s_wren_reg   <= 1'b0;
          ks_valid_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_addr   = s_addr_reg;
  assign s_wdata  = s_wdata_reg;
  assign s_wren   = s_wren_reg;
  assign ks_data  = ks_data_reg;
  assign ks_valid = ks_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_rc4_engine.sv
// ---------------------------------------------------------------------------
// tb_rc4_engine
//
// Directed testbench for rc4_engine. There are two instances, each with its
// own 256x8 S memory model. The memory registers its address and returns
// q = mem[address] in the following cycle.
//   u_dut_a : KEY_BYTES=3, OUT_LEN=10, DROP_N=0, key "Key"
//   u_dut_b : KEY_BYTES=4, OUT_LEN=3,  DROP_N=2, key "Wiki"
// ---------------------------------------------------------------------------
module tb_rc4_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // ---------------- instance A ----------------
  logic        start_a;
  logic [23:0] key_a;
  logic [7:0]  s_addr_a, s_wdata_a, s_q_a, ks_data_a;
  logic        s_wren_a, ks_valid_a, ready_a, busy_a, done_a;

  rc4_engine #(.KEY_BYTES(3), .OUT_LEN(10), .DROP_N(0)) u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_a),
    .secret_key (key_a),
    .s_addr     (s_addr_a),
    .s_wdata    (s_wdata_a),
    .s_wren     (s_wren_a),
    .s_q        (s_q_a),
    .ks_data    (ks_data_a),
    .ks_valid   (ks_valid_a),
    .ks_ready   (ready_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  logic [7:0] mem_a [256];
  logic [7:0] addr_q_a;
  always @(posedge clk) begin
    addr_q_a <= s_addr_a;
    if (s_wren_a) mem_a[s_addr_a] <= s_wdata_a;
  end
  assign s_q_a = mem_a[addr_q_a];

  // ---------------- instance B ----------------
  logic        start_b;
  logic [31:0] key_b;
  logic [7:0]  s_addr_b, s_wdata_b, s_q_b, ks_data_b;
  logic        s_wren_b, ks_valid_b, ready_b, busy_b, done_b;

  rc4_engine #(.KEY_BYTES(4), .OUT_LEN(3), .DROP_N(2)) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_b),
    .secret_key (key_b),
    .s_addr     (s_addr_b),
    .s_wdata    (s_wdata_b),
    .s_wren     (s_wren_b),
    .s_q        (s_q_b),
    .ks_data    (ks_data_b),
    .ks_valid   (ks_valid_b),
    .ks_ready   (ready_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  logic [7:0] mem_b [256];
  logic [7:0] addr_q_b;
  always @(posedge clk) begin
    addr_q_b <= s_addr_b;
    if (s_wren_b) mem_b[s_addr_b] <= s_wdata_b;
  end
  assign s_q_b = mem_b[addr_q_b];

  // ---------------- expected values ----------------
  logic [7:0] exp_key [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                               8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
`ifdef RC4_DROP_EN
  logic [7:0] exp_wiki [3] = '{8'hDB, 8'h6D, 8'h41};
`else
  logic [7:0] exp_wiki [3] = '{8'h60, 8'h44, 8'hDB};
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_s_addr"},   32'(s_addr_a),   32'd0);
    check({tag, "_s_wdata"},  32'(s_wdata_a),  32'd0);
    check({tag, "_s_wren"},   32'(s_wren_a),   32'd0);
    check({tag, "_ks_data"},  32'(ks_data_a),  32'd0);
    check({tag, "_ks_valid"}, 32'(ks_valid_a), 32'd0);
    check({tag, "_busy"},     32'(busy_a),     32'd0);
    check({tag, "_done"},     32'(done_a),     32'd0);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Collect the 10 "Key" bytes from instance A. If stall > 0, ks_ready is
  // held low for that many cycles per byte.
  task automatic collect_a(input string run, input int stall);
    logic [7:0] got;
    int t;
    for (int b = 0; b < 10; b++) begin
      t = 0;
      while (!ks_valid_a && t < 4000) begin
        @(negedge clk);
        t++;
      end
      if (!ks_valid_a) begin
        check({run, "_valid_timeout"}, 32'(ks_valid_a), 32'd1);
        return;
      end
      got = ks_data_a;
      check($sformatf("%s_byte%0d", run, b), 32'(got), 32'(exp_key[b]));
      $display("%s: byte %0d = %02h", run, b, got);
      if (stall > 0) begin
        for (int c = 0; c < stall; c++) begin
          @(negedge clk);
          check({run, "_stall_valid"}, 32'(ks_valid_a), 32'd1);
          check({run, "_stall_data"},  32'(ks_data_a),  32'(got));
        end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
      end else begin
        @(negedge clk);
      end
      check({run, "_gap"}, 32'(ks_valid_a), 32'd0);
    end
    check({run, "_done"},   32'(done_a),   32'd1);
    check({run, "_busy"},   32'(busy_a),   32'd0);
    check({run, "_s_wren"}, 32'(s_wren_a), 32'd0);
  endtask

  initial begin
    int t;
    reset_n = 1'b0;
    start_a = 1'b0; ready_a = 1'b0; key_a = '0;
    start_b = 1'b0; ready_b = 1'b0; key_b = '0;
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset_b_busy", 32'(busy_b), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- run 1: "Key", INIT pattern check, no backpressure ----
    key_a   = 24'h4B6579;
    ready_a = 1'b1;
    pulse_start_a();
    check("run1_busy", 32'(busy_a), 32'd1);
    for (int idx = 0; idx < 256; idx++) begin
      // A start pulse in the middle of INIT must not restart it
      if (idx == 100) start_a = 1'b1;
      if (idx == 101) start_a = 1'b0;
      check($sformatf("init_wren%0d", idx),  32'(s_wren_a),  32'd1);
      check($sformatf("init_addr%0d", idx),  32'(s_addr_a),  32'(idx));
      check($sformatf("init_wdata%0d", idx), 32'(s_wdata_a), 32'(idx));
      @(negedge clk);
    end
    check("post_init_wren", 32'(s_wren_a), 32'd0);
    check("post_init_addr", 32'(s_addr_a), 32'd0);
    $display("run1: INIT pattern observed");
    collect_a("run1", 0);

    // ---- run 2: restart from DONE with backpressure ----
    ready_a = 1'b0;
    pulse_start_a();
    check("run2_done_cleared", 32'(done_a), 32'd0);
    check("run2_busy", 32'(busy_a), 32'd1);
    collect_a("run2", 20);

    // ---- run 3: reset in mid-KSA, then a clean run ----
    pulse_start_a();
    repeat (400) @(negedge clk);
    pulse_start_a();                 // ignored while busy
    repeat (455) @(negedge clk);     // i is around 100 by now
    check("run3_busy_before_rst", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check_a_zero("midrst");
    repeat (2) @(negedge clk);
    check_a_zero("midrst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    ready_a = 1'b1;
    pulse_start_a();
    collect_a("run3", 0);
    $display("run3: reset mid-KSA and rerun complete");

    // ---- instance B: "Wiki" ----
    key_b   = 32'h57696B69;
    ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int b = 0; b < 3; b++) begin
      t = 0;
      while (!ks_valid_b && t < 4000) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("wiki_byte%0d", b), 32'(ks_data_b), 32'(exp_wiki[b]));
      $display("wiki: byte %0d = %02h", b, ks_data_b);
      @(negedge clk);
    end
    check("wiki_done", 32'(done_b), 32'd1);
    check("wiki_busy", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
